// File: rtl/fbc_ddr_burst_writer.sv
// fbc_ddr_burst_writer: buffers 256-bit FBC records in a FWFT FIFO and writes them to DDR as fixed-length bursts.
// Define FBC_DDR_WRAP_EN to wrap the address at ADDR_LIMIT; otherwise the writer stops in FULL until the next scan.
module fbc_ddr_burst_writer #(
  parameter real TCQ = 0.1,
  parameter int BURST_LEN = 8,
  parameter int FIFO_DEPTH = 64,
  parameter int ADDR_W = 30,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 30'h0100_0000,
  parameter logic [ADDR_W-1:0] ADDR_LIMIT = 30'h1100_0000
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              fbc_scan_en_i,
  input  logic              fbc_cache_vld_i,
  input  logic [255:0]      fbc_cache_data_i,
  output logic              ddr_cmd_vld_o,
  input  logic              ddr_cmd_rdy_i,
  output logic [ADDR_W-1:0] ddr_cmd_addr_o,
  output logic [7:0]        ddr_cmd_len_o,
  output logic              ddr_wr_vld_o,
  input  logic              ddr_wr_rdy_i,
  output logic [255:0]      ddr_wr_data_o,
  output logic              ddr_wr_last_o,
  output logic [31:0]       wr_words_o,
  output logic              overflow_o,
  output logic              busy_o
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(BURST_LEN);
  localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BURST_LEN * 32);
`ifdef FBC_DDR_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  if (TCQ < 0.0 || BURST_LEN < 2 || BURST_LEN > 64 || (BURST_LEN & (BURST_LEN - 1)) != 0 ||
      FIFO_DEPTH < 2 * BURST_LEN || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("fbc_ddr_burst_writer: invalid parameter set");
  end

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_FULL} state_t;

  state_t            r_state, w_next;
  logic [255:0]      r_mem [FIFO_DEPTH];
  logic [PW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [BW-1:0]     r_beat;
  logic [ADDR_W-1:0] r_addr;
  logic              r_pad, r_flush, r_restart, r_scan_d, r_ovf;
  logic [31:0]       r_words;

  logic w_empty, w_full, w_rise, w_fall, w_restart_go, w_cmd_hs, w_wr_hs, w_last_hs;
  logic w_pop, w_push, w_drop, w_go, w_at_limit;
  logic [ADDR_W-1:0] w_addr_nxt;

  assign w_empty      = r_count == '0;
  assign w_full       = r_count == CW'(FIFO_DEPTH);
  assign w_rise       = fbc_scan_en_i & ~r_scan_d;
  assign w_fall       = ~fbc_scan_en_i & r_scan_d;
  // a scan restart only takes effect once the previous scan has fully drained
  assign w_restart_go = (r_restart | w_rise) & (r_state == S_IDLE | r_state == S_FULL) & w_empty;
  assign w_cmd_hs     = ddr_cmd_vld_o & ddr_cmd_rdy_i;
  assign w_wr_hs      = ddr_wr_vld_o & ddr_wr_rdy_i;
  assign w_last_hs    = w_wr_hs & (r_beat == BW'(BURST_LEN - 1));
  // FULL discards the FIFO one word per cycle
  assign w_pop        = ~w_empty & (w_wr_hs | r_state == S_FULL);
  assign w_push       = fbc_cache_vld_i & (r_state != S_FULL | w_restart_go) & (~w_full | w_pop);
  assign w_drop       = (fbc_cache_vld_i & ~w_push) | (r_state == S_FULL & ~w_empty);
  assign w_go         = r_state == S_IDLE & (r_count >= CW'(BURST_LEN) | (r_flush & ~w_empty));
  assign w_addr_nxt   = r_addr + BURST_BYTES;
  assign w_at_limit   = w_addr_nxt == ADDR_LIMIT;

  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) r_state <= S_IDLE;
    else r_state <= w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = w_go ? S_CMD : S_IDLE;
      S_CMD:   w_next = w_cmd_hs ? S_DATA : S_CMD;
      S_DATA:  w_next = !w_last_hs ? S_DATA : (w_at_limit && !WRAP_EN) ? S_FULL : S_IDLE;
      S_FULL:  w_next = w_restart_go ? S_IDLE : S_FULL;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    ddr_cmd_vld_o  = r_state == S_CMD;
    ddr_cmd_addr_o = ddr_cmd_vld_o ? r_addr : '0;
    ddr_wr_vld_o   = r_state == S_DATA && (!w_empty || r_pad);
    ddr_wr_last_o  = r_state == S_DATA && r_beat == BW'(BURST_LEN - 1);
    ddr_wr_data_o  = (r_state == S_DATA && !w_empty) ? r_mem[r_rd_ptr] : '0;
  end

  always_ff @(posedge clk_i)
    if (w_push) r_mem[r_wr_ptr] <= fbc_cache_data_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_beat    <= '0;
      r_addr    <= BASE_ADDR;
      r_pad     <= 1'b0;
      r_flush   <= 1'b0;
      r_restart <= 1'b0;
      r_scan_d  <= 1'b0;
      r_ovf     <= 1'b0;
      r_words   <= '0;
    end else begin
      r_scan_d  <= fbc_scan_en_i;
      r_count   <= r_count + CW'(w_push) - CW'(w_pop);
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_flush   <= w_fall | (r_flush & ~(r_state == S_IDLE & w_empty));
      r_restart <= (r_restart | w_rise) & ~w_restart_go;
      if (w_go) r_pad <= r_flush;
      else if (w_last_hs) r_pad <= 1'b0;
      if (w_cmd_hs) r_beat <= '0;
      else if (w_wr_hs) r_beat <= r_beat + 1'b1;
      r_words   <= w_restart_go ? 32'(w_push) : r_words + 32'(w_push);
      r_ovf     <= (r_ovf & ~w_restart_go) | w_drop;
      if (w_restart_go) r_addr <= BASE_ADDR;
      else if (w_last_hs) r_addr <= (w_at_limit && WRAP_EN) ? BASE_ADDR : w_addr_nxt;
    end
  end

  assign ddr_cmd_len_o = 8'(BURST_LEN - 1);
  assign wr_words_o    = r_words;
  assign overflow_o    = r_ovf;
  assign busy_o        = r_state != S_IDLE || !w_empty;
endmodule

// File: tb/tb_fbc_ddr_burst_writer.sv
// tb_fbc_ddr_burst_writer: scoreboard bench; u_dut0 uses the default region, u_dut1 a two-burst region.
module tb_fbc_ddr_burst_writer;
  localparam logic [29:0] BASE = 30'h0100_0000;

  logic clk_i = 1'b0, rst_n_i = 1'b0, scan = 1'b0, vld = 1'b0, cmd_rdy = 1'b1, wr_rdy = 1'b1;
  logic [255:0] data = '0;
  logic c0_vld, w0_vld, w0_last, ovf0, busy0, c1_vld, w1_vld, w1_last, ovf1, busy1;
  logic [29:0] c0_addr, c1_addr;
  logic [7:0] c0_len, c1_len;
  logic [255:0] w0_data, w1_data;
  logic [31:0] words0, words1;
  logic [38:0] sv0, sv1;

  logic [29:0] q_a0[$], q_a1[$];
  logic [256:0] q_b0[$], q_b1[$];
  logic [40:0] q_stat[$];
  string q_nm[$];
  int n_pass = 0, n_tot = 0;
  bit chk1 = 1'b0;
  logic [29:0] ea;
  logic [256:0] eb;
  logic [40:0] es;
  string en;

  always #5 clk_i = ~clk_i;

  fbc_ddr_burst_writer u_dut0 (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .fbc_scan_en_i(scan), .fbc_cache_vld_i(vld),
    .fbc_cache_data_i(data), .ddr_cmd_vld_o(c0_vld), .ddr_cmd_rdy_i(cmd_rdy),
    .ddr_cmd_addr_o(c0_addr), .ddr_cmd_len_o(c0_len), .ddr_wr_vld_o(w0_vld),
    .ddr_wr_rdy_i(wr_rdy), .ddr_wr_data_o(w0_data), .ddr_wr_last_o(w0_last),
    .wr_words_o(words0), .overflow_o(ovf0), .busy_o(busy0)
  );

  fbc_ddr_burst_writer #(.ADDR_LIMIT(30'h0100_0200)) u_dut1 (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .fbc_scan_en_i(scan), .fbc_cache_vld_i(vld),
    .fbc_cache_data_i(data), .ddr_cmd_vld_o(c1_vld), .ddr_cmd_rdy_i(cmd_rdy),
    .ddr_cmd_addr_o(c1_addr), .ddr_cmd_len_o(c1_len), .ddr_wr_vld_o(w1_vld),
    .ddr_wr_rdy_i(wr_rdy), .ddr_wr_data_o(w1_data), .ddr_wr_last_o(w1_last),
    .wr_words_o(words1), .overflow_o(ovf1), .busy_o(busy1)
  );

  assign sv0 = {words0, ovf0, busy0, c0_vld, w0_vld, w0_last, |c0_addr, |w0_data};
  assign sv1 = {words1, ovf1, busy1, c1_vld, w1_vld, w1_last, |c1_addr, |w1_data};

  function automatic logic [255:0] rv(int k);
    return {8{k}};
  endfunction

  function automatic logic [38:0] st_vec(int w, bit o, bit b, logic [4:0] x);
    return {w[31:0], o, b, x};
  endfunction

  task automatic check(string nm, logic [256:0] act, logic [256:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // monitor: compares every DUT handshake and every queued status snapshot
  always @(negedge clk_i) begin
    if (rst_n_i && c0_vld && cmd_rdy) begin
      if (q_a0.size() != 0) ea = q_a0.pop_front(); else ea = '1;
      check("dut0_cmd_addr", 257'(c0_addr), 257'(ea));
      check("dut0_cmd_len", 257'(c0_len), 257'(7));
    end
    if (rst_n_i && w0_vld && wr_rdy) begin
      if (q_b0.size() != 0) eb = q_b0.pop_front(); else eb = '1;
      check("dut0_beat", {w0_last, w0_data}, eb);
    end
    if (chk1 && rst_n_i && c1_vld && cmd_rdy) begin
      if (q_a1.size() != 0) ea = q_a1.pop_front(); else ea = '1;
      check("dut1_cmd_addr", 257'(c1_addr), 257'(ea));
    end
    if (chk1 && rst_n_i && w1_vld && wr_rdy) begin
      if (q_b1.size() != 0) eb = q_b1.pop_front(); else eb = '1;
      check("dut1_beat", {w1_last, w1_data}, eb);
    end
    if (q_stat.size() != 0) begin
      es = q_stat.pop_front();
      en = q_nm.pop_front();
      case (es[40:39])
        2'd0:    check(en, 257'(sv0), 257'(es[38:0]));
        2'd1:    check(en, 257'(sv1), 257'(es[38:0]));
        default: check(en, 257'(q_a0.size() + q_b0.size() + q_a1.size() + q_b1.size()), 257'(es[38:0]));
      endcase
    end
  end

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic rec(int k);
    vld = 1'b1;
    data = rv(k);
    tick();
    vld = 1'b0;
  endtask

  task automatic push0(logic [29:0] a, int k, int n);
    q_a0.push_back(a);
    for (int i = 0; i < 8; i++) q_b0.push_back({i == 7, (i < n) ? rv(k + i) : 256'd0});
  endtask

  task automatic push1(logic [29:0] a, int k, int n);
    q_a1.push_back(a);
    for (int i = 0; i < 8; i++) q_b1.push_back({i == 7, (i < n) ? rv(k + i) : 256'd0});
  endtask

  task automatic expect_stat(string nm, logic [1:0] kind, logic [38:0] v);
    q_nm.push_back(nm);
    q_stat.push_back({kind, v});
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000 && (busy0 || q_a0.size() != 0 || q_b0.size() != 0); i++) tick();
    tick(2);
  endtask

  initial begin
    tick(3);
    expect_stat("reset0", 2'd0, '0);
    expect_stat("reset1", 2'd1, '0);
    tick(2);
    rst_n_i = 1'b1;
    tick(2);
    // two full bursts
    scan = 1'b1;
    tick(3);
    push0(BASE, 1, 8);
    push0(BASE + 30'h100, 9, 8);
    for (int k = 1; k <= 16; k++) rec(k);
    wait_idle();
    expect_stat("t1_status", 2'd0, st_vec(16, 0, 0, 5'b0));
    // partial burst flushed with zero pads
    scan = 1'b0;
    tick(3);
    scan = 1'b1;
    tick(3);
    push0(BASE, 101, 8);
    push0(BASE + 30'h100, 109, 3);
    for (int k = 101; k <= 111; k++) rec(k);
    scan = 1'b0;
    wait_idle();
    expect_stat("t2_flush", 2'd0, st_vec(11, 0, 0, 5'b0));
    // FIFO overflow while write side stalls
    scan = 1'b1;
    tick(3);
    wr_rdy = 1'b0;
    for (int j = 0; j < 8; j++) push0(BASE + 30'(j * 256), 201 + 8 * j, 8);
    for (int k = 201; k <= 270; k++) rec(k);
    tick(130);
    expect_stat("t3_stall", 2'd0, st_vec(64, 1, 1, 5'b01001));
    tick(2);
    wr_rdy = 1'b1;
    wait_idle();
    expect_stat("t3_drain", 2'd0, st_vec(64, 1, 0, 5'b0));
    // scan restart during an active burst
    wr_rdy = 1'b0;
    push0(BASE + 30'h800, 301, 8);
    for (int k = 301; k <= 308; k++) rec(k);
    tick(5);
    scan = 1'b0;
    tick();
    scan = 1'b1;
    tick(2);
    expect_stat("t4_pending", 2'd0, st_vec(72, 1, 1, 5'b01001));
    tick(2);
    wr_rdy = 1'b1;
    wait_idle();
    expect_stat("t4_restart", 2'd0, st_vec(0, 0, 0, 5'b0));
    push0(BASE, 311, 8);
    for (int k = 311; k <= 318; k++) rec(k);
    wait_idle();
    expect_stat("t4_base", 2'd0, st_vec(8, 0, 0, 5'b0));
    // asynchronous reset in the middle of DATA
    wr_rdy = 1'b0;
    push0(BASE + 30'h100, 401, 8);
    for (int k = 401; k <= 408; k++) rec(k);
    tick(5);
    rst_n_i = 1'b0;
    #1;
    q_a0.delete();
    q_b0.delete();
    q_a1.delete();
    q_b1.delete();
    expect_stat("t6_async0", 2'd0, '0);
    expect_stat("t6_async1", 2'd1, '0);
    scan = 1'b0;
    tick(2);
    rst_n_i = 1'b1;
    wr_rdy = 1'b1;
    tick(2);
    // region limit on u_dut1, normal run on u_dut0
    scan = 1'b1;
    tick(3);
    chk1 = 1'b1;
    push0(BASE, 501, 8);
    push0(BASE + 30'h100, 509, 8);
    push0(BASE + 30'h200, 517, 8);
    push1(BASE, 501, 8);
    push1(BASE + 30'h100, 509, 8);
`ifdef FBC_DDR_WRAP_EN
    push1(BASE, 517, 8);
`endif
    for (int k = 501; k <= 524; k++) rec(k);
    wait_idle();
    tick(5);
    expect_stat("t5_limit0", 2'd0, st_vec(24, 0, 0, 5'b0));
`ifdef FBC_DDR_WRAP_EN
    expect_stat("t5_limit1", 2'd1, st_vec(24, 0, 0, 5'b0));
`else
    expect_stat("t5_limit1", 2'd1, st_vec(24, 1, 1, 5'b0));
`endif
    expect_stat("queues_drained", 2'd2, '0);
    tick(4);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
